fifo_burst_reader: RTL and testbench

- Read-side companion to the team's tt_um FIFO: drains it in fixed-length bursts and presents the words on a valid/ready stream with a burst-end marker.
- Starts a burst only when the FIFO reports it is not almost-empty.
- Issues FIFO pops with one-cycle read latency and buffers the returned words in a 2-entry output buffer, so downstream backpressure never loses data.

---
 rtl/fifo_burst_reader_if.sv | 24 ++
 rtl/fifo_burst_reader.sv | 142 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Valid/ready stream carrying burst data with a burst-end marker.
// The master drives data/valid/last; the slave drives ready.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a FIFO in fixed-length bursts onto a valid/ready stream.
// FIFO_BURST_READER_TIMEOUT_EN adds a 1-word flush after idle timeout.
module fifo_burst_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int BURST_LEN      = 2,
  parameter int LEN_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  fifo_burst_reader_if.master   m,
  output logic                  busy,
  output logic [7:0]            bursts_done
);

  if (BURST_LEN < 1 || (1 << LEN_WIDTH) <= BURST_LEN ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fifo_burst_reader: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  pop_cnt;
  logic [LEN_WIDTH-1:0]  last_idx;
  logic                  pending;
  logic                  pending_last;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  accept;
  logic                  last_pop;
  logic                  start;
  logic [2:0]            occ;
  logic [2:0]            room;

  assign accept = m.valid && m.ready;

  // Buffer slots plus the pop in flight must leave room for this pop.
  assign occ  = {1'b0, count} + {2'b00, pending};
  assign room = 3'd2 + {2'b00, accept};

  assign fifo_rd_en = (state == BURST) && !fifo_empty
                    && (occ < room);
  assign last_pop   = fifo_rd_en && (pop_cnt == last_idx);

  assign m.valid = (count != 2'd0);
  assign m.data  = buf_data[rd_ptr];
  assign m.last  = m.valid && buf_last[rd_ptr];
  assign busy    = (state != IDLE);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] idle_cnt;
  logic          flush;
  logic          timeout;

  assign timeout  = (idle_cnt == IW'(TIMEOUT_CYCLES));
  assign start    = !fifo_empty && (!fifo_almost_empty || timeout);
  assign last_idx = flush ? '0 : LEN_WIDTH'(BURST_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      flush    <= 1'b0;
    end else if (state == IDLE) begin
      if (fifo_empty || start)
        idle_cnt <= '0;
      else if (fifo_almost_empty)
        idle_cnt <= idle_cnt + 1'b1;
      if (start)
        flush <= fifo_almost_empty;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign start    = !fifo_empty && !fifo_almost_empty;
  assign last_idx = LEN_WIDTH'(BURST_LEN - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pop_cnt      <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      buf_data[0]  <= '0;
      buf_data[1]  <= '0;
      buf_last     <= 2'b00;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      bursts_done  <= 8'd0;
    end else begin
      pending      <= fifo_rd_en;
      pending_last <= last_pop;
      if (fifo_rd_en)
        pop_cnt <= pop_cnt + 1'b1;
      if (pending) begin
        buf_data[wr_ptr] <= fifo_rd_data;
        buf_last[wr_ptr] <= pending_last;
        wr_ptr           <= !wr_ptr;
      end
      if (accept)
        rd_ptr <= !rd_ptr;
      count <= count + {1'b0, pending}
                     - {1'b0, accept};
      if (accept && m.last)
        bursts_done <= bursts_done + 8'd1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= BURST;
            pop_cnt <= '0;
          end
        end
        BURST: begin
          if (last_pop)
            state <= DRAIN;
        end
        DRAIN: begin
          if (accept && m.last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized scoreboard bench for fifo_burst_reader with a FIFO model.
// Directed phases cover latency, backpressure, stall, reset, wrap.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_almost_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          busy;
  logic [7:0]    bursts_done;

  fifo_burst_reader_if #(.DATA_WIDTH(DW)) s_if ();

  fifo_burst_reader #(
    .DATA_WIDTH    (DW),
    .BURST_LEN     (BL),
    .LEN_WIDTH     (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty       (fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_en       (fifo_rd_en),
    .m                (s_if),
    .busy             (busy),
    .bursts_done      (bursts_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq [$];
  logic [DW:0]   exp_q [$];
  bit            force_empty = 1'b0;
  logic          rd_en_s = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            model_bursts = 0;
  int            pops_total = 0;
  int            beats_total = 0;
  int            burst_pops = 0;
  int            cur_len = BL;
  int            last_owed = 0;
  bit            flush_cand = 1'b0;
  bit            hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  task automatic upd_flags();
    fifo_empty        = force_empty || (fq.size() == 0);
    fifo_almost_empty = (fq.size() <= 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO model: pop strobed last cycle, data valid this cycle.
  always begin
    @(posedge clk);
    #1;
    if (rd_en_s) begin
      if (fq.size() > 0) fifo_rd_data = fq.pop_front();
      else fifo_rd_data = DW'($urandom);
    end
    rd_en_s = 1'b0;
    upd_flags();
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [DW:0]   e;
    logic [DW-1:0] w;
    logic          acc;
    rd_en_s = fifo_rd_en;
    if (rst) begin
      exp_q.delete();
      model_bursts = 0;
      pops_total   = 0;
      beats_total  = 0;
      burst_pops   = 0;
      last_owed    = 0;
      hold         = 1'b0;
    end else begin
      acc = s_if.valid && s_if.ready;
      chk("bursts_done", bursts_done, model_bursts % 256);
      if (!busy) flush_cand = fifo_almost_empty;
      if (s_if.valid) chk("busy_with_valid", busy, 1);
      if (hold) begin
        chk("hold_valid", s_if.valid, 1);
        chk("hold_data", s_if.data, hold_data);
        chk("hold_last", s_if.last, hold_last);
      end
      if (fifo_rd_en) begin
        chk("rd_en_while_empty", fifo_empty, 0);
        if (burst_pops == 0) begin
          chk("start_before_last_accepted", last_owed, 0);
          cur_len = BL;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
          if (flush_cand) cur_len = 1;
`endif
        end
        w = (fq.size() > 0) ? fq[0] : '0;
        burst_pops++;
        if (burst_pops == cur_len) begin
          exp_q.push_back({1'b1, w});
          burst_pops = 0;
          last_owed++;
        end else begin
          exp_q.push_back({1'b0, w});
        end
        pops_total++;
      end
      if (acc) begin
        if (exp_q.size() == 0) begin
          chk("beat_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", s_if.data, e[DW-1:0]);
          chk("m_last", s_if.last, e[DW]);
          if (e[DW]) begin
            model_bursts++;
            last_owed--;
          end
        end
        beats_total++;
      end
      chk("occupancy_le_2", (pops_total - beats_total) <= 2, 1);
      hold      = s_if.valid && !s_if.ready;
      hold_data = s_if.data;
      hold_last = s_if.last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_bits;
    logic [7:0] v_bits;
    int         pops;
    int         pop_at;
    bit         found;
    bit         done;

    s_if.ready = 1'b0;
    upd_flags();
    step(3);
    @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", s_if.valid, 0);
    chk("rst_last", s_if.last, 0);
    chk("rst_data", s_if.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bursts", bursts_done, 0);
    step(1);
    rst = 1'b0;

    // Latency / throughput
    fq = '{8'hA1, 8'hB2, 8'hC3};
    s_if.ready = 1'b1;
    upd_flags();
    rd_bits = '0;
    v_bits  = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_bits[i] = fifo_rd_en;
      v_bits[i]  = s_if.valid;
    end
    chk("t1_rd_en_pattern", rd_bits, 8'b0000_0110);
    chk("t1_valid_pattern", v_bits, 8'b0001_1000);
    chk("t1_bursts_done", bursts_done, 1);
    chk("t1_fifo_left", fq.size(), 1);
    if (fq.size() > 0) chk("t1_c3_kept", fq[0], 8'hC3);

    // Backpressure
    step(1);
    fq = '{8'hA1, 8'hB2, 8'hC3};
    s_if.ready = 1'b0;
    upd_flags();
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_rd_en) pops++;
      if (i == 5) chk("t2_hold_data", s_if.data, 8'hA1);
    end
    chk("t2_pops", pops, 2);
    step(1);
    s_if.ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t2_bursts_done", bursts_done, 2);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Underflow stall
    step(1);
    fq = '{8'hA1, 8'hB2, 8'hC3};
    upd_flags();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (fifo_rd_en) found = 1'b1;
    end
    chk("t3_first_pop", found, 1);
    step(1);
    force_empty = 1'b1;
    upd_flags();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_rd_en", fifo_rd_en, 0);
      step(1);
    end
    force_empty = 1'b0;
    upd_flags();
    repeat (8) @(negedge clk);
    chk("t3_bursts_done", bursts_done, 3);

    // Reset in DRAIN under backpressure
    step(1);
    fq = '{8'hA1, 8'hB2, 8'hC3};
    s_if.ready = 1'b0;
    upd_flags();
    repeat (5) @(negedge clk);
    chk("t4_busy_pre", busy, 1);
    chk("t4_valid_pre", s_if.valid, 1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_valid_post", s_if.valid, 0);
    chk("t4_busy_post", busy, 0);
    chk("t4_bursts_post", bursts_done, 0);
    step(1);
    fq.push_back(8'hD4);
    fq.push_back(8'hE5);
    s_if.ready = 1'b1;
    upd_flags();
    repeat (8) @(negedge clk);
    chk("t4_fresh_burst", bursts_done, 1);

    // Single word below threshold
    step(1);
    fq.delete();
    fq.push_back(8'h77);
    upd_flags();
    pops   = 0;
    pop_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        pops++;
        if (pop_at < 0) pop_at = i;
      end
    end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    chk("t5_flush_pops", pops, 1);
    chk("t5_flush_cycle", (pop_at >= 16) && (pop_at <= 18), 1);
    chk("t5_flush_burst", bursts_done, 2);
`else
    chk("t5_no_pop", pops, 0);
    chk("t5_word_kept", fq.size(), 1);
`endif

    // Randomized traffic until the burst counter wraps
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    fq.delete();
    upd_flags();
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      step(1);
      if (model_bursts >= 256) begin
        done = 1'b1;
      end else begin
        s_if.ready  = ($urandom_range(0, 3) != 0);
        force_empty = ($urandom_range(0, 9) == 0);
        if (fq.size() < 8 && $urandom_range(0, 1) == 1)
          fq.push_back(DW'($urandom));
        upd_flags();
      end
    end
    chk("t6_budget", done, 1);
    chk("t6_wrap_zero", bursts_done, 0);
    s_if.ready  = 1'b1;
    force_empty = 1'b0;
    upd_flags();
    repeat (40) @(negedge clk);
    chk("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
